// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Purpose  : Column scanner and frame-based debouncer for a 4x3 tenkey pad.
//            The columns are driven one-hot, one after another. The row lines
//            are synchronised, and one sample per column builds a 12-bit frame
//            image. At every frame end the image is classified as NONE,
//            SINGLE(code) or MULTI. A debounce FSM turns a run of frames into
//            one registered key code plus a one-cycle valid strobe.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            row[3:0]  - pad row lines, active-high, asynchronous
//            col[2:0]  - one-hot column drive
//            key_code  - last accepted key (0-9 digits, 10 '*', 11 '#')
//            key_valid - one-cycle pulse on each newly accepted key
//            key_held  - accepted key still pressed (debounced)
//            multi     - most recent frame saw two or more keys
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
  parameter int SCAN_DIV = 4,   // cycles per column slot (>= 3)
  parameter int DEBOUNCE = 3    // identical frames to accept/release (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi
);

  localparam int                  c_SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]          c_DEB       = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Frame image bit position p = row*3 + col; this maps a position to the
  // key code printed on the pad.
  function automatic logic [3:0] pos_to_code(input int p);
    case (p)
      0:       pos_to_code = 4'd1;
      1:       pos_to_code = 4'd2;
      2:       pos_to_code = 4'd3;
      3:       pos_to_code = 4'd4;
      4:       pos_to_code = 4'd5;
      5:       pos_to_code = 4'd6;
      6:       pos_to_code = 4'd7;
      7:       pos_to_code = 4'd8;
      8:       pos_to_code = 4'd9;
      9:       pos_to_code = 4'd10;  // '*'
      10:      pos_to_code = 4'd0;
      11:      pos_to_code = 4'd11;  // '#'
      default: pos_to_code = 4'd0;
    endcase
  endfunction

  logic [3:0]          r_row_s1;
  logic [3:0]          r_row_s2;
  logic [c_SLOT_W-1:0] r_slot;
  logic [2:0]          r_col;
  logic [11:0]         r_frame;
  state_t              r_state;
  logic [3:0]          r_cand;
  logic [3:0]          r_cnt;

  logic        w_slot_last;
  logic        w_frame_end;
  logic [11:0] w_slot_bits;
  logic [11:0] w_image;
  logic [3:0]  w_nbits;
  logic [3:0]  w_code;
  logic        w_single;
  logic        w_multi_res;
  logic        w_same;
  logic [3:0]  w_cnt_inc;

  assign col         = r_col;
  assign w_slot_last = (r_slot == c_SLOT_LAST);
  assign w_frame_end = w_slot_last && r_col[2];

  // Only the column being driven contributes to this slot's image bits.
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign w_slot_bits[gr*3 + gc] = r_col[gc] & r_row_s2[gr];
    end
  end

  // The image evaluated at frame end must include the final column's sample,
  // which is only being captured on this very edge.
  assign w_image = r_frame | w_slot_bits;

  always_comb begin
    w_nbits = 4'd0;
    w_code  = 4'd0;
    for (int p = 0; p < 12; p++) begin
      w_nbits = w_nbits + 4'(w_image[p]);
      if (w_image[p]) w_code = pos_to_code(p);
    end
  end

  assign w_single    = (w_nbits == 4'd1);
  assign w_multi_res = (w_nbits >= 4'd2);
  assign w_same      = w_single && (w_code == r_cand);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Row synchroniser, slot counter, column rotation and frame image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= 4'd0;
      r_row_s2 <= 4'd0;
      r_slot   <= '0;
      r_col    <= 3'b001;
      r_frame  <= 12'd0;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
      if (w_slot_last) begin
        r_slot <= '0;
        r_col  <= {r_col[1:0], r_col[2]};
        // Clear at frame end so the next frame starts from an empty image.
        r_frame <= w_frame_end ? 12'd0 : w_image;
      end else begin
        r_slot <= r_slot + c_SLOT_W'(1);
      end
    end
  end

  // Debounce FSM; it only advances on frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cand    <= 4'd0;
      r_cnt     <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (w_frame_end) begin
        multi <= w_multi_res;
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_code;
              r_cnt  <= 4'd1;
              if (c_DEB == 4'd1) begin
                r_state   <= S_HELD;
                key_code  <= w_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                r_state <= S_CHECK;
              end
            end
          end
          S_CHECK: begin
            if (w_same) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_DEB) begin
                r_state   <= S_HELD;
                key_code  <= r_cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else if (w_single) begin
              r_cand <= w_code;
              r_cnt  <= 4'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (!w_same) begin
              r_cnt <= 4'd1;
              // With a single-frame debounce one missing frame is a release.
              if (c_DEB == 4'd1) begin
                r_state  <= S_IDLE;
                key_held <= 1'b0;
              end else begin
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (w_same) begin
              r_state <= S_HELD;
            end else begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_DEB) begin
                r_state  <= S_IDLE;
                key_held <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Self-checking bench for keypad_scan. A pad model drives the row
//            lines from the column drive and a set of pressed keys. Key
//            changes are applied on frame boundaries. A frame-level reference
//            model predicts the outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 3 * SCAN_DIV;

  localparam int M_IDLE    = 0;
  localparam int M_CHECK   = 1;
  localparam int M_HELD    = 2;
  localparam int M_RELEASE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi;

  // pressed[k] = 1 when the key whose code is k is held down.
  logic [11:0] pressed = 12'd0;
  int pad_code [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          pulses = 0;
  int          e = 0;       // rising edges since reset release

  // Reference model state
  int m_st = M_IDLE, m_cand = 0, m_cnt = 0, m_code = 0;
  int m_held = 0, m_multi = 0, m_valid = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi    (multi)
  );

  // Pad: a row is high when a pressed key sits on a driven column.
  always_comb begin
    row = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (col[c] && pressed[pad_code[r][c]]) row[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cand = 0; m_cnt = 0; m_code = 0;
    m_held = 0; m_multi = 0; m_valid = 0;
  endtask

  task automatic accept();
    m_st = M_HELD; m_code = m_cand; m_valid = 1; m_held = 1;
  endtask

  // Applies the debounce rules to one complete frame of constant key state.
  task automatic model_frame(input logic [11:0] mask);
    int n;
    int k;
    bit single, same;
    n = $countones(mask);
    k = 0;
    for (int i = 0; i < 12; i++) if (mask[i]) k = i;
    single  = (n == 1);
    same    = single && (k == m_cand);
    m_multi = (n >= 2) ? 1 : 0;
    case (m_st)
      M_IDLE: if (single) begin
        m_cand = k; m_cnt = 1;
        if (DEBOUNCE == 1) accept(); else m_st = M_CHECK;
      end
      M_CHECK: begin
        if (same) begin
          m_cnt++;
          if (m_cnt == DEBOUNCE) accept();
        end else if (single) begin
          m_cand = k; m_cnt = 1;
        end else m_st = M_IDLE;
      end
      M_HELD: if (!same) begin
        m_cnt = 1;
        if (DEBOUNCE == 1) begin m_st = M_IDLE; m_held = 0; end
        else m_st = M_RELEASE;
      end
      default: begin
        if (same) m_st = M_HELD;
        else begin
          m_cnt++;
          if (m_cnt == DEBOUNCE) begin m_st = M_IDLE; m_held = 0; end
        end
      end
    endcase
  endtask

  // Called at a negedge; holds `mask` for nf whole frames, checking every cycle.
  task automatic run_frames(input logic [11:0] mask, input int nf);
    for (int f = 0; f < nf; f++) begin
      pressed = mask;
      for (int i = 0; i < FRAME; i++) begin
        @(posedge clk);
        e++;
        if (e % FRAME == 0) model_frame(mask);
        #1;
        chk("col", col, 32'(1 << ((e / SCAN_DIV) % 3)));
        chk("key_valid", key_valid, m_valid);
        chk("key_held", key_held, m_held);
        chk("key_code", key_code, m_code);
        chk("multi", multi, m_multi);
        if (key_valid) pulses++;
        m_valid = 0;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge; asserts reset asynchronously for ncyc cycles.
  task automatic apply_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    chk("rst_key_held", key_held, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_multi", multi, 0);
    chk("rst_col", col, 3'b001);
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    e = 0;
  endtask

  initial begin
    logic [11:0] mask;
    int sel;
    model_reset();
    repeat (3) @(negedge clk);
    apply_reset(2);
    run_frames(12'd0, 2);

    // Clean press of '5'
    pulses = 0;
    run_frames(12'd1 << 5, 10);
    chk("clean_pulses", pulses, 1);
    chk("clean_code", key_code, 5);
    run_frames(12'd0, 4);
    chk("clean_released", key_held, 0);

    // Bounce: '0' for only two frames
    pulses = 0;
    run_frames(12'd1 << 0, 2);
    run_frames(12'd0, 3);
    chk("bounce_pulses", pulses, 0);

    // Multi-key '1'+'9', then release '1'
    pulses = 0;
    run_frames((12'd1 << 1) | (12'd1 << 9), 5);
    chk("multi_flag", multi, 1);
    chk("multi_pulses", pulses, 0);
    run_frames(12'd1 << 9, 5);
    chk("multi_drop", multi, 0);
    chk("multi_then9_pulses", pulses, 1);
    chk("multi_then9_code", key_code, 9);
    run_frames(12'd0, 4);

    // Release glitch on '#'
    pulses = 0;
    run_frames(12'd1 << 11, 5);
    run_frames(12'd0, 1);
    chk("glitch_held", key_held, 1);
    run_frames(12'd1 << 11, 3);
    chk("glitch_pulses", pulses, 1);
    run_frames(12'd0, 3);
    chk("glitch_released", key_held, 0);
    run_frames(12'd0, 1);

    // Reset while '*' is held; it must be accepted again afterwards
    run_frames(12'd1 << 10, 5);
    chk("star_held", key_held, 1);
    pulses = 0;
    apply_reset(3);
    run_frames(12'd1 << 10, 5);
    chk("star_reaccept_pulses", pulses, 1);
    chk("star_reaccept_code", key_code, 10);
    run_frames(12'd0, 4);

    // Randomised segments of none / single / double presses
    for (int s = 0; s < 80; s++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2) mask = 12'd0;
      else if (sel <= 7) mask = 12'd1 << $urandom_range(0, 11);
      else mask = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
      run_frames(mask, $urandom_range(1, 5));
      if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Matrix scanner and debouncer for the 4x3 tenkey pad that feeds the electronic lock. It drives the pad columns one at a time and samples the row lines. Each key press is debounced across whole scan frames. Each press produces exactly one registered key code with a one-cycle valid strobe, which the lock controller consumes as its key input.

## Interface
- SCAN_DIV, 4: cycles each column is driven; legal range is 3 or more, to cover the 2-flop row synchroniser.
- DEBOUNCE, 3: consecutive identical frames needed to accept a press or a release; legal range is 1 to 15.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- row  in  4  pad row lines; active-high; asynchronous; synchronised internally by 2 flops
- col  out  3  one-hot column drive; col[c]=1 drives column c
- key_code  out  4  last accepted key; 0-9 are the digits, 10 is '*', 11 is '#'
- key_valid  out  1  one-cycle pulse when a new key is accepted
- key_held  out  1  high while the accepted key remains pressed, after debounce
- multi  out  1  high while the most recent frame saw two or more keys

## Operation
- Pad layout, as (row, col):
  - r0 is 1 2 3
  - r1 is 4 5 6
  - r2 is 7 8 9
  - r3 is * 0 #
- Column scanning:
  - A slot counter divides by SCAN_DIV.
  - col rotates 001 → 010 → 100 → 001.
  - Each pattern lasts SCAN_DIV cycles.
  - One frame is 3 slots, i.e. 3*SCAN_DIV cycles.
- Row sampling:
  - The synchronised row vector is sampled on the last cycle of each slot.
  - Samples accumulate into a 12-bit frame image.
- Frame result, evaluated at the frame end (last cycle of the col=100 slot):
  - NONE when 0 bits are set.
  - SINGLE(code) when exactly 1 bit is set.
  - MULTI when 2 or more bits are set.
- multi is updated at every frame end: 1 if the result is MULTI, else 0.
- Debounce FSM, updated only at frame end. Its state is IDLE, CHECK, HELD or RELEASE, plus a candidate code cand and a 4-bit frame count cnt.
  - IDLE:
    - On SINGLE(k): go to CHECK with cand=k, cnt=1; if DEBOUNCE=1, go directly to HELD and accept.
    - On any other result: stay in IDLE.
  - CHECK:
    - On SINGLE(cand): cnt increments; when cnt reaches DEBOUNCE, go to HELD and accept.
    - On SINGLE(k≠cand): restart with cand=k, cnt=1.
    - On NONE or MULTI: go to IDLE.
  - Accept action: key_code<=cand, key_valid pulses for 1 cycle, key_held<=1.
  - HELD:
    - On SINGLE(cand): stay in HELD.
    - On any other result: go to RELEASE with cnt=1.
  - RELEASE:
    - On SINGLE(cand): go back to HELD; there is no new key_valid.
    - On any other result: cnt increments; when cnt reaches DEBOUNCE, go to IDLE with key_held<=0.
- key_code keeps the last accepted value until the next accept.
- A different key pressed during HELD or RELEASE is not accepted until the FSM returns to IDLE.

## Timing
- Reset values, applied asynchronously on rst_n low:
  - col=001 and slot counter=0
  - frame image=0
  - state=IDLE, cnt=0
  - key_code=0, key_valid=0, key_held=0, multi=0
  - synchroniser flops=0
- Scanning after reset release:
  - col=001 for the first SCAN_DIV cycles after rst_n deasserts.
  - Scanning continues free-running from there.
- Output registration and latency:
  - key_valid, key_held and multi are registered.
  - They change on the clock edge that ends the deciding frame.
  - They are visible in the following cycle.
- Worst-case accept latency is (DEBOUNCE+1) frames plus 2 cycles from a stable press.
- Release latency is DEBOUNCE frames after the key is no longer seen.
- A row change inside a slot is seen only if it is stable 2 cycles before the sample point.
- Reset asserted mid-frame or in HELD:
  - All state clears immediately.
  - A key still pressed after release of reset is re-accepted as a new press with a fresh key_valid.
- key_valid is never asserted for 2 consecutive cycles.

## Test plan
Bench setup: SCAN_DIV=4, DEBOUNCE=3, frame = 12 cycles. The bench models the pad as row[r] = OR over c of (col[c] AND pressed(r,c)).
- Reset check: hold rst_n=0, then release. All outputs are 0. col sequence is 001×4, 010×4, 100×4, repeating.
- Clean press: press '5' (r1,c1) for 120 cycles. Exactly one key_valid occurs, with key_code=5, within 50 cycles of the press. key_held=1 until 3 frames after release.
- Bounce reject: press '0' for 2 frames, then release. There is no key_valid and key_held stays 0.
- Multi-key:
  - Press '1' and '9' together; multi=1 and there is no key_valid.
  - Release '1'; multi drops to 0 and key_valid pulses once with key_code=9.
- Release glitch: hold '#' until accepted (key_code=11), then drop it for 1 frame. key_held stays 1 and there is no second key_valid. A full release for 3 frames gives key_held=0.
- Reset mid-HELD:
  - While '*' is held (key_code=10), pulse rst_n low for 3 cycles.
  - key_held and key_code go to 0 immediately and col=001.
  - With the key still pressed, key_valid pulses again with key_code=10.
